uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one uart_tx serializer between NUM_REQ byte producers (debug console, CPU MMIO port, boot monitor).
- Selects a requester and presents its byte on the serializer's data input.
- Generates the active-low start_n falling edge and tracks the ready_to_send handshake through the frame.
- Returns a per-requester ack once the serializer has latched the byte, and guards the start handshake with a timeout.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter and start-handshake sequencer that
// shares one uart_tx serializer between NUM_REQ byte producers.
//
// Handshake: a requester raises req[i] with its byte on req_data[8*i+:8] and
// holds both until it sees a one-cycle ack[i]. ack[i] means the serializer has
// latched the byte, signalled by uart_ready falling while uart_start_n is
// asserted. If uart_ready does not fall within TIMEOUT cycles, the transfer is
// abandoned with a timeout_err pulse and no ack. The requester keeps req
// raised and is retried after the other requesters have had their turn.
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int START_HOLD = 4,
   parameter int TIMEOUT    = 4096,
   localparam int GRANT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_data,
   output logic [NUM_REQ-1:0]     ack,
   input  logic                   uart_ready,
   output logic                   uart_start_n,
   output logic [7:0]             uart_data,
   output logic                   busy,
   output logic [GRANT_W-1:0]     grant_idx,
   output logic                   timeout_err,
   output logic [1:0]             state_dbg
);

   localparam int HOLD_W = $clog2(START_HOLD + 1);
   localparam int TO_W   = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARM   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              state;
   logic [GRANT_W-1:0]  rr_ptr;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [TO_W-1:0]     to_cnt;

   logic                win_found;
   logic [GRANT_W-1:0]  win_idx;
   logic [GRANT_W-1:0]  cand;
   logic [7:0]          win_data;
   logic [GRANT_W-1:0]  next_ptr;

   assign state_dbg = state;

   // Pointer after the current grant; wraps at NUM_REQ-1 so unused indices are never reached.
   assign next_ptr = (grant_idx == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   // Round-robin search from rr_ptr upward; scanning offsets downward lets the nearest requester win.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = GRANT_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Byte of the winning requester.
   always_comb begin
      win_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == GRANT_W'(i)) win_data = req_data[8*i +: 8];
      end
   end

   // Arbitration / start-handshake FSM; all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         uart_start_n <= 1'b1;
         uart_data    <= '0;
         ack          <= '0;
         busy         <= 1'b0;
         grant_idx    <= '0;
         timeout_err  <= 1'b0;
         rr_ptr       <= '0;
         hold_cnt     <= '0;
         to_cnt       <= '0;
      end else begin
         ack         <= '0;
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               // uart_ready low means the serializer cannot accept a start edge yet.
               if (uart_ready && win_found) begin
                  uart_data    <= win_data;
                  grant_idx    <= win_idx;
                  uart_start_n <= 1'b0;
                  hold_cnt     <= HOLD_W'(1);
                  to_cnt       <= '0;
                  busy         <= 1'b1;
                  state        <= S_ARM;
               end
            end
            S_ARM: begin
               to_cnt <= to_cnt + 1'b1;
               if (hold_cnt == HOLD_W'(START_HOLD)) uart_start_n <= 1'b1;
               else                                 hold_cnt     <= hold_cnt + 1'b1;
               // Latch beats timeout when both happen on the same cycle.
               if (!uart_ready) begin
                  ack          <= NUM_REQ'(1) << grant_idx;
                  uart_start_n <= 1'b1;
                  state        <= S_DRAIN;
               end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                  timeout_err  <= 1'b1;
                  uart_start_n <= 1'b1;
                  rr_ptr       <= next_ptr;
                  busy         <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            S_DRAIN: begin
               // Frame in flight; the serializer raises uart_ready after its stop bit.
               if (uart_ready) begin
                  rr_ptr <= next_ptr;
                  busy   <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (NUM_REQ=2 and NUM_REQ=3, TIMEOUT=16),
// each attached to a behavioural serializer model and a serial-line receiver.
module tb_uart_tx_arbiter;
   localparam int BAUD = 8;
   localparam int TOUT = 16;

   // clock / reset
   logic clk = 1'b0;
   logic rst_a, rst_b, ser_rst;
   int   cyc = 0;
   always #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   // DUT-side signals; channel 0 = instance a, channel 1 = instance b
   logic [1:0]  req_a, ack_a;
   logic [15:0] rd_a;
   logic [0:0]  grant_a;
   logic [2:0]  req_b, ack_b;
   logic [23:0] rd_b;
   logic [1:0]  grant_b;
   logic        start_n_w[2];
   logic [7:0]  data_w[2];
   logic        busy_w[2];
   logic        to_w[2];
   logic [1:0]  st_w[2];
   logic        uart_ready_w[2];
   logic        line_w[2];
   logic        ser_en[2];
   logic        rdy_hold[2];
   logic [2:0]  ack_w[2];
   logic [1:0]  grant_w[2];

   assign ack_w[0]   = {1'b0, ack_a};
   assign ack_w[1]   = ack_b;
   assign grant_w[0] = {1'b0, grant_a};
   assign grant_w[1] = grant_b;

   uart_tx_arbiter #(.NUM_REQ(2), .START_HOLD(4), .TIMEOUT(TOUT)) dut_a (
      .clk(clk), .rst(rst_a), .req(req_a), .req_data(rd_a), .ack(ack_a),
      .uart_ready(uart_ready_w[0]), .uart_start_n(start_n_w[0]), .uart_data(data_w[0]),
      .busy(busy_w[0]), .grant_idx(grant_a), .timeout_err(to_w[0]), .state_dbg(st_w[0]));

   uart_tx_arbiter #(.NUM_REQ(3), .START_HOLD(4), .TIMEOUT(TOUT)) dut_b (
      .clk(clk), .rst(rst_b), .req(req_b), .req_data(rd_b), .ack(ack_b),
      .uart_ready(uart_ready_w[1]), .uart_start_n(start_n_w[1]), .uart_data(data_w[1]),
      .busy(busy_w[1]), .grant_idx(grant_b), .timeout_err(to_w[1]), .state_dbg(st_w[1]));

   // Serializer models: 2-stage start edge detect, latch 6 cycles later, 10-bit frame.
   for (genvar c = 0; c < 2; c++) begin : g_ser
      logic       s1, s2, pend, act, rdy, ln;
      logic [2:0] lat;
      logic [3:0] bitn, bcnt;
      logic [9:0] sh;
      assign line_w[c]       = ln;
      assign uart_ready_w[c] = rdy_hold[c] ? 1'b0 : rdy;
      always @(posedge clk) begin
         if (ser_rst) begin
            s1 <= 1'b1; s2 <= 1'b1; pend <= 1'b0; act <= 1'b0; rdy <= 1'b1; ln <= 1'b1;
            lat <= '0; bitn <= '0; bcnt <= '0; sh <= '1;
         end else begin
            s1 <= start_n_w[c];
            s2 <= s1;
            if (!act && !pend && ser_en[c] && s2 && !s1) begin
               pend <= 1'b1;
               lat  <= '0;
            end
            if (pend) begin
               lat <= lat + 1'b1;
               if (lat == 3'd5) begin
                  pend <= 1'b0; act <= 1'b1; rdy <= 1'b0;
                  sh <= {1'b1, data_w[c], 1'b0};
                  bitn <= '0; bcnt <= '0; ln <= 1'b0;
               end
            end
            if (act) begin
               bcnt <= bcnt + 1'b1;
               if (bcnt == 4'(BAUD - 1)) begin
                  bcnt <= '0;
                  if (bitn == 4'd9) begin
                     act <= 1'b0; rdy <= 1'b1; ln <= 1'b1;
                  end else begin
                     bitn <= bitn + 1'b1;
                     ln   <= sh[bitn + 4'd1];
                  end
               end
            end
         end
      end
   end

   // Requester models: req stays high until the issued byte count has been acked.
   int iss[5] = '{default: 0};
   int don[5] = '{default: 0};
   assign req_a = {iss[1] != don[1], iss[0] != don[0]};
   assign req_b = {iss[4] != don[4], iss[3] != don[3], iss[2] != don[2]};
   initial forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (ack_a[i] && don[i] != iss[i]) don[i]++;
      for (int i = 0; i < 3; i++) if (ack_b[i] && don[2+i] != iss[2+i]) don[2+i]++;
   end

   // Scoreboard: event entry = {is_timeout, channel, grant[1:0], data[7:0]}
   logic [11:0] exp_q[$];
   logic [7:0]  line_q[$];
   int checks = 0;
   int errors = 0;

   // driver tasks
   task automatic issue(input int r, input logic [7:0] d, input int n);
      if (r < 2) rd_a[8*r +: 8] = d;
      else       rd_b[8*(r-2) +: 8] = d;
      iss[r] = iss[r] + n;
   endtask

   task automatic expect_ev(input logic kind, input logic chan, input logic [1:0] g, input logic [7:0] d);
      exp_q.push_back({kind, chan, g, d});
      if (!kind) line_q.push_back(d);
   endtask

   task automatic check_reset(input int c);
      logic [17:0] got;
      got = {start_n_w[c], data_w[c], busy_w[c], to_w[c], ack_w[c], grant_w[c], st_w[c]};
      checks++;
      if (got !== 18'h20000) begin
         errors++;
         $display("FAIL reset_values ch%0d: got %h required %h", c, got, 18'h20000);
      end
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || line_q.size() != 0 || busy_w[0] || busy_w[1]) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL wait_idle: still pending after %0d cycles (exp %0d line %0d)", n, exp_q.size(), line_q.size());
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_to(input int c, input int n, input int budget);
      int seen = 0;
      int k = 0;
      while (seen < n && k < budget) begin
         @(negedge clk);
         k++;
         if (to_w[c]) seen++;
      end
      checks++;
      if (seen < n) begin errors++; $display("FAIL wait_timeout ch%0d: saw %0d required %0d", c, seen, n); end
   endtask

   task automatic wait_ack(input int c, input int budget);
      int k = 0;
      while (ack_w[c] == 3'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (ack_w[c] == 3'b0) begin errors++; $display("FAIL wait_ack ch%0d: no ack within %0d cycles", c, budget); end
   endtask

   // Monitor: events, start hold length, no-grant-while-not-ready, serial line frames
   logic        prev_sn[2]   = '{1'b1, 1'b1};
   logic        prev_line[2] = '{1'b1, 1'b1};
   int          low_cnt[2]   = '{0, 0};
   int          gcyc[2]      = '{0, 0};
   logic        rx_act[2]    = '{1'b0, 1'b0};
   logic [3:0]  rx_cnt[2];
   logic [3:0]  rx_n[2];
   logic [9:0]  rx_bits[2];
   logic [11:0] e, got;
   logic [7:0]  lb;
   initial forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
         if (ack_w[c] != 3'b0 || to_w[c]) begin
            checks++;
            got = {to_w[c], 1'(c), grant_w[c], data_w[c]};
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL event ch%0d: got %h required none", c, got);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin errors++; $display("FAIL event ch%0d: got %h required %h", c, got, e); end
               checks++;
               if (e[11]) begin
                  if (ack_w[c] != 3'b0 || busy_w[c] || (cyc - gcyc[c]) != TOUT) begin
                     errors++;
                     $display("FAIL timeout_pulse ch%0d: ack %b busy %b delay %0d required ack 0 busy 0 delay %0d",
                              c, ack_w[c], busy_w[c], cyc - gcyc[c], TOUT);
                  end
               end else if (ack_w[c] !== (3'b001 << e[9:8])) begin
                  errors++;
                  $display("FAIL ack_bits ch%0d: got %b required %b", c, ack_w[c], 3'b001 << e[9:8]);
               end
            end
         end
         if (prev_sn[c] && !start_n_w[c]) begin
            gcyc[c]    = cyc;
            low_cnt[c] = 1;
         end else if (!start_n_w[c]) begin
            low_cnt[c]++;
         end else if (!prev_sn[c]) begin
            checks++;
            if (low_cnt[c] != 4) begin errors++; $display("FAIL start_hold ch%0d: low %0d cycles required 4", c, low_cnt[c]); end
         end
         prev_sn[c] = start_n_w[c];
         if (rdy_hold[c]) begin
            checks++;
            if (busy_w[c] || !start_n_w[c]) begin
               errors++;
               $display("FAIL not_ready_grant ch%0d: busy %b start_n %b required 0 1", c, busy_w[c], start_n_w[c]);
            end
         end
         if (!rx_act[c]) begin
            if (prev_line[c] && !line_w[c]) begin
               rx_act[c] = 1'b1; rx_cnt[c] = '0; rx_n[c] = '0;
            end
         end else begin
            rx_cnt[c] = rx_cnt[c] + 4'd1;
            if (rx_cnt[c] == ((rx_n[c] == 4'd0) ? 4'(BAUD/2) : 4'(BAUD))) begin
               rx_cnt[c] = '0;
               rx_bits[c][rx_n[c]] = line_w[c];
               rx_n[c] = rx_n[c] + 4'd1;
               if (rx_n[c] == 4'd10) begin
                  rx_act[c] = 1'b0;
                  checks++;
                  if (line_q.size() == 0) begin
                     errors++;
                     $display("FAIL line_frame ch%0d: got %b required none", c, rx_bits[c]);
                  end else begin
                     lb = line_q.pop_front();
                     if (rx_bits[c] !== {1'b1, lb, 1'b0}) begin
                        errors++;
                        $display("FAIL line_frame ch%0d: got %b required %b", c, rx_bits[c], {1'b1, lb, 1'b0});
                     end
                  end
               end
            end
         end
         prev_line[c] = line_w[c];
      end
   end

   // Directed stimulus with hand-computed grant order
   initial begin
      rst_a = 1'b1; rst_b = 1'b1; ser_rst = 1'b1;
      rd_a = '0; rd_b = '0;
      ser_en = '{1'b1, 1'b1};
      rdy_hold = '{1'b0, 1'b0};
      repeat (3) @(negedge clk);
      check_reset(0);
      check_reset(1);
      ser_rst = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
      repeat (2) @(negedge clk);

      // both requesters, two bytes each, from rr_ptr=0: 0,1,0,1
      expect_ev(0, 0, 2'd0, 8'h11); expect_ev(0, 0, 2'd1, 8'h22);
      expect_ev(0, 0, 2'd0, 8'h11); expect_ev(0, 0, 2'd1, 8'h22);
      issue(0, 8'h11, 2); issue(1, 8'h22, 2);
      wait_idle(2000);

      // single byte A5 from requester 0 (rr_ptr back at 0)
      expect_ev(0, 0, 2'd0, 8'hA5);
      issue(0, 8'hA5, 1);
      wait_idle(600);

      // serializer deaf: rr_ptr=1 -> timeout on 1, then 0; then serializer returns
      ser_en[0] = 1'b0;
      expect_ev(1, 0, 2'd1, 8'h22); expect_ev(1, 0, 2'd0, 8'h33);
      expect_ev(0, 0, 2'd1, 8'h22); expect_ev(0, 0, 2'd0, 8'h33);
      issue(1, 8'h22, 1); issue(0, 8'h33, 1);
      wait_to(0, 2, 400);
      ser_en[0] = 1'b1;
      wait_idle(800);

      // uart_ready held low from reset: no grant until it rises
      rdy_hold[0] = 1'b1;
      @(posedge clk); #1 rst_a = 1'b1;
      @(negedge clk); rst_a = 1'b0;
      expect_ev(0, 0, 2'd0, 8'h5A);
      issue(0, 8'h5A, 1);
      repeat (40) @(negedge clk);
      rdy_hold[0] = 1'b0;
      wait_idle(600);

      // reset during DRAIN: outputs clear at once, byte re-granted after release
      expect_ev(0, 0, 2'd0, 8'h3C); expect_ev(0, 0, 2'd0, 8'h3C);
      issue(0, 8'h3C, 2);
      wait_ack(0, 200);
      repeat (5) @(negedge clk);
      @(posedge clk); #1 rst_a = 1'b1;
      #1 check_reset(0);
      @(negedge clk); rst_a = 1'b0;
      wait_idle(800);

      // NUM_REQ=3: grant 1, then req 001 wraps to 0, then rr_ptr=2 with req 101 gives 2 then 0
      expect_ev(0, 1, 2'd1, 8'h77);
      issue(3, 8'h77, 1);
      wait_idle(600);
      expect_ev(0, 1, 2'd0, 8'h88);
      issue(2, 8'h88, 1);
      wait_idle(600);
      expect_ev(0, 1, 2'd1, 8'h77);
      issue(3, 8'h77, 1);
      wait_idle(600);
      expect_ev(0, 1, 2'd2, 8'hAA); expect_ev(0, 1, 2'd0, 8'h99);
      issue(2, 8'h99, 1); issue(4, 8'hAA, 1);
      wait_idle(1000);

      // final report
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
